// File: rtl/mps_multicycle_core.sv
// Multi-cycle MPS CPU core: a FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready
// instruction and data memory ports, branch/jump/halt and retire/halted status.
module mps_multicycle_core #(
  parameter int DATA_WIDTH  = 16,
  parameter int IADDR_WIDTH = 8,
  parameter int DADDR_WIDTH = 8,
  parameter int RESET_PC    = 0
) (
  input  logic                   clock,
  input  logic                   nreset,
  output logic                   imem_req,
  output logic [IADDR_WIDTH-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [15:0]            imem_value,
  output logic                   dmem_req,
  output logic                   dmem_wenable,
  output logic [DADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]  dmem_wvalue,
  input  logic                   dmem_ready,
  input  logic [DATA_WIDTH-1:0]  dmem_rvalue,
  output logic                   retire,
  output logic                   halted,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_started;
  logic [IADDR_WIDTH-1:0] r_pc;
  logic [IADDR_WIDTH-1:0] r_next_pc;
  logic [IADDR_WIDTH-1:0] w_exec_pc;
  logic [15:0]            r_ir;
  logic [DATA_WIDTH-1:0]  r_opa;
  logic [DATA_WIDTH-1:0]  r_opb;
  logic [DATA_WIDTH-1:0]  r_opd;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [DATA_WIDTH-1:0]  w_alu;
  logic [DATA_WIDTH-1:0]  w_imm;
  logic [DATA_WIDTH-1:0]  r_regs [16];
  logic [3:0]             w_op;
  logic [3:0]             w_rd;
  logic [3:0]             w_ra;
  logic [3:0]             w_rb;
  logic                   w_writes_rd;

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[11:8];
  assign w_ra        = r_ir[7:4];
  assign w_rb        = r_ir[3:0];
  assign w_imm       = DATA_WIDTH'($signed(r_ir[7:0]));
  assign w_writes_rd = (w_op >= OP_ADD) && (w_op <= OP_LD);

  // Handshake (both ports): req is held from the request cycle up to and including
  // the cycle ready is sampled high; addr/wenable/wvalue come from registers frozen
  // over that window; ready is ignored whenever req is low.
  // r_started keeps imem_req low until the first edge after reset release.
  assign imem_req     = (r_state == S_FETCH) && r_started;
  assign imem_addr    = r_pc;
  assign dmem_req     = (r_state == S_MEM);
  assign dmem_wenable = (r_state == S_MEM) && (w_op == OP_ST);
  assign dmem_addr    = DADDR_WIDTH'(r_opa);
  assign dmem_wvalue  = r_opb;
  assign retire       = (r_state == S_WB);
  assign halted       = (r_state == S_HALTED) || ((r_state == S_WB) && (w_op == OP_HALT));
  assign dbg_state    = r_state;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_FETCH;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_started <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (imem_req && imem_ready) w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = ((w_op == OP_LD) || (w_op == OP_ST)) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ready) w_next_state = S_WB;
      S_WB:     w_next_state = (w_op == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Shift amounts at or beyond the word width flush the result to zero.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD: w_alu = r_opa + r_opb;
      OP_SUB: w_alu = r_opa - r_opb;
      OP_AND: w_alu = r_opa & r_opb;
      OP_OR:  w_alu = r_opa | r_opb;
      OP_XOR: w_alu = r_opa ^ r_opb;
      OP_SHL: if (r_opb < DATA_WIDTH'(DATA_WIDTH)) w_alu = r_opa << r_opb;
      OP_SHR: if (r_opb < DATA_WIDTH'(DATA_WIDTH)) w_alu = r_opa >> r_opb;
      OP_LI:  w_alu = w_imm;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_exec_pc = r_pc + IADDR_WIDTH'(1);
    case (w_op)
      OP_BEQZ: if (r_opd == '0)
                 w_exec_pc = r_pc + IADDR_WIDTH'(1) + IADDR_WIDTH'($signed(r_ir[7:0]));
      OP_JMP:  w_exec_pc = IADDR_WIDTH'(r_opa);
      OP_HALT: w_exec_pc = r_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_pc      <= IADDR_WIDTH'(RESET_PC);
      r_next_pc <= IADDR_WIDTH'(RESET_PC);
      r_ir      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_opd     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (imem_req && imem_ready) r_ir <= imem_value;
        S_DECODE: begin
          r_opa <= r_regs[w_ra];
          r_opb <= r_regs[w_rb];
          r_opd <= r_regs[w_rd];
        end
        S_EXEC: begin
          r_result  <= w_alu;
          r_next_pc <= w_exec_pc;
        end
        S_MEM:    if (dmem_ready && (w_op == OP_LD)) r_result <= dmem_rvalue;
        S_WB:     r_pc <= r_next_pc;
        default:  ;
      endcase
    end
  end

  // r0 is never written, so it reads back as zero without a read-side mux.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WB) && w_writes_rd && (w_rd != 4'd0)) begin
      r_regs[w_rd] <= r_result;
    end
  end

endmodule

// File: tb/tb_mps_multicycle_core.sv
// Bench for mps_multicycle_core: directed and random programs run against an
// instruction-level reference model; memories answer with configurable wait states.
module tb_mps_multicycle_core;

  localparam int DW  = 16;
  localparam int IAW = 8;
  localparam int DAW = 8;

  logic           clock = 1'b0;
  logic           nreset = 1'b0;
  logic           imem_req;
  logic [IAW-1:0] imem_addr;
  logic           imem_ready = 1'b0;
  logic [15:0]    imem_value = '0;
  logic           dmem_req;
  logic           dmem_wenable;
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wvalue;
  logic           dmem_ready = 1'b0;
  logic [DW-1:0]  dmem_rvalue = '0;
  logic           retire;
  logic           halted;
  logic [2:0]     dbg_state;

  always #5 clock = ~clock;

  mps_multicycle_core #(
    .DATA_WIDTH(DW), .IADDR_WIDTH(IAW), .DADDR_WIDTH(DAW), .RESET_PC(0)
  ) dut (
    .clock(clock), .nreset(nreset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_value(imem_value),
    .dmem_req(dmem_req), .dmem_wenable(dmem_wenable), .dmem_addr(dmem_addr),
    .dmem_wvalue(dmem_wvalue), .dmem_ready(dmem_ready), .dmem_rvalue(dmem_rvalue),
    .retire(retire), .halted(halted), .dbg_state(dbg_state)
  );

  logic [15:0] imem   [256];
  logic [15:0] b_dmem [256];
  logic [15:0] m_dmem [256];
  logic [24:0] exp_q[$];
  logic [7:0]  exp_pc_q[$];

  int vectors = 0;
  int miscompares = 0;
  int exp_retires;
  bit exp_halt;
  int imem_wmin, imem_wmax, dmem_wmin, dmem_wmax, first_iwait;
  bit abort_on_mem = 1'b0;
  bit aborted;
  int cyc, retires, first_retire_cyc, last_retire_cyc, halt_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int d, input int a, input int b);
    return {4'(op), 4'(d), 4'(a), 4'(b)};
  endfunction

  function automatic logic [15:0] li(input int d, input int imm);
    return {4'h8, 4'(d), 8'(imm)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i]   = 16'h0000;
      b_dmem[i] = 16'($urandom);
      m_dmem[i] = b_dmem[i];
    end
  endtask

  task automatic set_waits(input int imin, input int imax, input int dmin, input int dmax, input int fi);
    imem_wmin = imin; imem_wmax = imax; dmem_wmin = dmin; dmem_wmax = dmax; first_iwait = fi;
  endtask

  // Instruction-level model: executes up to max_steps instructions straight from the ISA rules.
  task automatic iss_run(input int max_steps);
    int regs[16];
    int pc, nxt, op, d, a, b, imm, ra, rb, rd, val, addr;
    bit wr;
    for (int i = 0; i < 16; i++) regs[i] = 0;
    pc = 0;
    exp_pc_q.delete();
    exp_q.delete();
    exp_halt = 1'b0;
    exp_retires = 0;
    for (int s = 0; s < max_steps; s++) begin
      exp_pc_q.push_back(8'(pc));
      op = int'(imem[pc][15:12]); d = int'(imem[pc][11:8]);
      a  = int'(imem[pc][7:4]);   b = int'(imem[pc][3:0]);
      imm = int'(imem[pc][7:0]);
      if (imm > 127) imm = imm - 256;
      ra = regs[a]; rb = regs[b]; rd = regs[d];
      nxt = (pc + 1) % 256;
      wr = 1'b0; val = 0;
      exp_retires++;
      if (op == 15) begin
        exp_halt = 1'b1;
        break;
      end
      case (op)
        1: begin wr = 1; val = (ra + rb) & 'hFFFF; end
        2: begin wr = 1; val = (ra - rb) & 'hFFFF; end
        3: begin wr = 1; val = ra & rb; end
        4: begin wr = 1; val = ra | rb; end
        5: begin wr = 1; val = ra ^ rb; end
        6: begin wr = 1; val = (rb >= 16) ? 0 : ((ra << rb) & 'hFFFF); end
        7: begin wr = 1; val = (rb >= 16) ? 0 : (ra >> rb); end
        8: begin wr = 1; val = imm & 'hFFFF; end
        9: begin
          addr = ra % 256; wr = 1; val = int'(m_dmem[addr]);
          exp_q.push_back({1'b0, 8'(addr), 16'h0000});
        end
        10: begin
          addr = ra % 256;
          exp_q.push_back({1'b1, 8'(addr), 16'(rb)});
          m_dmem[addr] = 16'(rb);
        end
        11: if (rd == 0) nxt = (pc + 1 + imm + 256) % 256;
        12: nxt = ra % 256;
        default: ;
      endcase
      if (wr && d != 0) regs[d] = val;
      pc = nxt;
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_value = '0; dmem_rvalue = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_imem_req",     32'(imem_req), 32'd0);
    check("rst_imem_addr",    32'(imem_addr), 32'd0);
    check("rst_dmem_req",     32'(dmem_req), 32'd0);
    check("rst_dmem_wenable", 32'(dmem_wenable), 32'd0);
    check("rst_dmem_addr",    32'(dmem_addr), 32'd0);
    check("rst_dmem_wvalue",  32'(dmem_wvalue), 32'd0);
    check("rst_retire",       32'(retire), 32'd0);
    check("rst_halted",       32'(halted), 32'd0);
    @(negedge clock);
    nreset = 1'b1;
  endtask

  // Cycle-by-cycle memory responder and checker; runs until halt+4, end of the
  // expected fetch stream, an abort on the first data request, or the cycle budget.
  task automatic run(input int budget);
    bit done = 0, i_busy = 0, d_busy = 0, first_fetch = 1;
    int i_wait = 0, d_wait = 0;
    logic [7:0]  i_hold = '0, d_addr = '0;
    logic        d_we = 1'b0;
    logic [15:0] d_wv = '0;
    logic [24:0] got;
    cyc = 0; retires = 0; first_retire_cyc = -1; last_retire_cyc = -1; halt_cyc = -1;
    aborted = 1'b0;
    while (!done) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check("first_imem_req", 32'(imem_req), 32'd1);
        check("first_imem_addr", 32'(imem_addr), 32'd0);
      end
      if (retire) begin
        retires++;
        if (first_retire_cyc < 0) first_retire_cyc = cyc;
        last_retire_cyc = cyc;
      end
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (halt_cyc >= 0) begin
        check("halt_imem_req", 32'(imem_req), 32'd0);
        check("halt_dmem_req", 32'(dmem_req), 32'd0);
        check("halt_hold", 32'(halted), 32'd1);
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        if (cyc >= halt_cyc + 4) done = 1;
      end else begin
        if (imem_req) begin
          if (!i_busy) begin
            if (exp_pc_q.size() == 0) begin
              done = 1; imem_ready = 1'b0;
            end else begin
              i_busy = 1; i_hold = imem_addr;
              i_wait = (first_fetch && first_iwait >= 0) ? first_iwait
                                                         : int'($urandom_range(imem_wmax, imem_wmin));
              first_fetch = 0;
            end
          end else begin
            check("imem_addr_stable", 32'(imem_addr), 32'(i_hold));
          end
          if (i_busy) begin
            if (i_wait == 0) begin
              imem_ready = 1'b1; imem_value = imem[imem_addr];
              check("fetch_pc", 32'(imem_addr), 32'(exp_pc_q.pop_front()));
              i_busy = 0;
            end else begin
              i_wait--; imem_ready = 1'b0; imem_value = 16'($urandom);
            end
          end
        end else begin
          imem_ready = 1'($urandom); imem_value = 16'($urandom);
        end
        if (dmem_req && !done) begin
          if (!d_busy) begin
            d_busy = 1; d_addr = dmem_addr; d_we = dmem_wenable; d_wv = dmem_wvalue;
            d_wait = int'($urandom_range(dmem_wmax, dmem_wmin));
            if (abort_on_mem) begin
              done = 1; aborted = 1'b1; dmem_ready = 1'b0;
            end
          end else begin
            check("dmem_addr_stable", 32'(dmem_addr), 32'(d_addr));
            check("dmem_we_stable", 32'(dmem_wenable), 32'(d_we));
            if (d_we) check("dmem_wv_stable", 32'(dmem_wvalue), 32'(d_wv));
          end
          if (d_busy && !done) begin
            if (d_wait == 0) begin
              dmem_ready = 1'b1;
              got = {dmem_wenable, dmem_addr, dmem_wenable ? dmem_wvalue : 16'h0000};
              if (exp_q.size() == 0) check("dmem_access_expected", 32'(exp_q.size()), 32'd1);
              else check("dmem_access", 32'(got), 32'(exp_q.pop_front()));
              if (dmem_wenable) begin
                b_dmem[dmem_addr] = dmem_wvalue; dmem_rvalue = 16'($urandom);
              end else begin
                dmem_rvalue = b_dmem[dmem_addr];
              end
              d_busy = 0;
            end else begin
              d_wait--; dmem_ready = 1'b0; dmem_rvalue = 16'($urandom);
            end
          end
        end else if (!dmem_req) begin
          dmem_ready = 1'($urandom); dmem_rvalue = 16'($urandom);
        end
      end
      if (!done && cyc >= budget) begin
        check("run_within_budget", 32'(done), 32'd1);
        done = 1;
      end
    end
    if (!aborted) begin
      check("mem_queue_drained", 32'(exp_q.size()), 32'd0);
      check("retire_count", 32'(retires), 32'(exp_retires));
      check("halted_final", 32'(halted), 32'(exp_halt));
      if (exp_halt) check("fetch_queue_drained", 32'(exp_pc_q.size()), 32'd0);
    end
  endtask

  initial begin
    // Reset mid-MEM: outputs drop immediately, fetch restarts at RESET_PC.
    clear_mem();
    imem[0] = li(1, 7); imem[1] = ins(9, 2, 1, 0); imem[2] = ins(15, 0, 0, 0);
    iss_run(100);
    set_waits(0, 0, 0, 0, -1);
    abort_on_mem = 1'b1;
    do_reset();
    run(100);
    abort_on_mem = 1'b0;
    check("t1_reached_mem", 32'(aborted), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("t1_dmem_req", 32'(dmem_req), 32'd0);
    check("t1_imem_addr", 32'(imem_addr), 32'd0);
    check("t1_halted", 32'(halted), 32'd0);
    check("t1_imem_req", 32'(imem_req), 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    check("t1_refetch_req", 32'(imem_req), 32'd1);
    check("t1_refetch_addr", 32'(imem_addr), 32'd0);

    // Zero-wait five-instruction program.
    clear_mem();
    imem[0] = li(1, 5); imem[1] = li(2, -3); imem[2] = ins(1, 3, 1, 2);
    imem[3] = ins(10, 0, 1, 3); imem[4] = ins(15, 0, 0, 0);
    iss_run(100);
    set_waits(0, 0, 0, 0, -1);
    do_reset();
    run(200);
    check("t2_halt_cycle", 32'(halt_cyc), 32'd21);
    check("t2_last_retire", 32'(last_retire_cyc), 32'd21);
    check("t2_retires", 32'(retires), 32'd5);

    // Same program with the first fetch held off three cycles.
    iss_run(100);
    set_waits(0, 0, 0, 0, 3);
    do_reset();
    run(200);
    check("t3_first_retire", 32'(first_retire_cyc), 32'd7);
    check("t3_halt_cycle", 32'(halt_cyc), 32'd24);

    // BEQZ self-loop at 0x10.
    clear_mem();
    imem[0] = li(1, 16); imem[1] = ins(12, 0, 1, 0); imem[16] = {4'hB, 4'h0, 8'hFF};
    iss_run(6);
    set_waits(0, 1, 0, 1, -1);
    do_reset();
    run(200);

    // BEQZ not taken on nonzero register.
    clear_mem();
    imem[0] = li(2, 1); imem[1] = li(1, 16); imem[2] = ins(12, 0, 1, 0);
    imem[16] = {4'hB, 4'h2, 8'h40}; imem[17] = ins(15, 0, 0, 0);
    iss_run(100);
    do_reset();
    run(200);

    // PC wrap from 0xFF to 0x00.
    clear_mem();
    imem[0] = li(1, -1); imem[1] = ins(12, 0, 1, 0);
    iss_run(7);
    do_reset();
    run(200);

    // Loads into r0 and r4 with two-cycle data waits.
    clear_mem();
    b_dmem[32] = 16'hBEEF; m_dmem[32] = 16'hBEEF;
    imem[0] = li(1, 32); imem[1] = ins(9, 0, 1, 0); imem[2] = ins(9, 4, 1, 0);
    imem[3] = li(5, 40); imem[4] = ins(10, 0, 5, 4); imem[5] = li(6, 41);
    imem[6] = ins(10, 0, 6, 0); imem[7] = ins(15, 0, 0, 0);
    iss_run(100);
    set_waits(0, 0, 2, 2, -1);
    do_reset();
    run(300);

    // ALU boundaries and reserved opcode.
    clear_mem();
    imem[0]  = li(1, 1);          imem[1]  = ins(2, 2, 0, 1);
    imem[2]  = li(3, 20);         imem[3]  = ins(6, 4, 1, 3);
    imem[4]  = li(5, 15);         imem[5]  = ins(6, 6, 1, 5);
    imem[6]  = ins(7, 7, 6, 5);   imem[7]  = ins(13, 8, 1, 1);
    imem[8]  = ins(10, 0, 1, 2);  imem[9]  = li(9, 2);
    imem[10] = ins(10, 0, 9, 4);  imem[11] = li(10, 3);
    imem[12] = ins(10, 0, 10, 7); imem[13] = li(11, 4);
    imem[14] = ins(10, 0, 11, 8); imem[15] = ins(10, 0, 3, 6);
    imem[16] = ins(15, 0, 0, 0);
    iss_run(100);
    set_waits(0, 1, 0, 1, -1);
    do_reset();
    run(400);

    // Random programs with random wait states.
    for (int p = 0; p < 4; p++) begin
      int op;
      clear_mem();
      for (int i = 0; i < 256; i++) begin
        op = int'($urandom_range(15, 0));
        if (op == 15 && $urandom_range(7, 0) != 0) op = 10;
        if (op == 0) op = 8;
        imem[i] = ins(op, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                      int'($urandom_range(15, 0)));
      end
      iss_run(50);
      set_waits(0, 2, 0, 3, -1);
      do_reset();
      run(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
